// File: rtl/motor_pwm_ctrl.sv
// Per-motor drive stage: slew-limited PWM, safe direction reversal with dead time,
// immediate brake and latched fault shutdown for one motor driver channel.
module motor_pwm_ctrl #(
   parameter int unsigned PRESCALE   = 64,
   parameter int unsigned RAMP_TICKS = 4,
   parameter int unsigned DEADTIME   = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       brake,
   input  logic       direction,
   input  logic [4:0] pwm,
   input  logic       fault,
   output logic       pwm_out,
   output logic       dir_out,
   output logic       brake_out,
   output logic       fault_latched,
   output logic       busy
);

   localparam int unsigned DUTY_W = 5;
   localparam int unsigned PRE_W  = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;
   localparam int unsigned RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
   localparam int unsigned DEAD_W = (DEADTIME > 1)   ? $clog2(DEADTIME)   : 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_RUN       = 3'd1;
   localparam logic [2:0] S_RAMP_DOWN = 3'd2;
   localparam logic [2:0] S_REVERSE   = 3'd3;
   localparam logic [2:0] S_DEADTIME  = 3'd4;
   localparam logic [2:0] S_BRAKE     = 3'd5;
   localparam logic [2:0] S_FAULT     = 3'd6;

   logic [2:0]        state, next_state;
   logic [PRE_W-1:0]  prescaler, prescaler_nxt;
   logic [DUTY_W-1:0] pcnt, pcnt_nxt;
   logic [DUTY_W-1:0] applied_duty, duty_nxt;
   logic [RAMP_W-1:0] ramp_cnt, ramp_cnt_nxt;
   logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
   logic              pwm_nxt, dir_nxt, brake_nxt, fault_nxt, busy_nxt;

   logic              tick_c, boundary_c, ramp_step_c, dead_done_c;
   logic              cur_ramp_c, nxt_ramp_c;
   logic [DUTY_W-1:0] target_c;

   // Free-running PWM timebase and period-boundary events
   always_comb begin
      tick_c      = (prescaler == PRE_W'(PRESCALE - 1));
      boundary_c  = tick_c && (pcnt == 5'd31);
      ramp_step_c = boundary_c && (ramp_cnt == RAMP_W'(RAMP_TICKS - 1));
      dead_done_c = boundary_c && (dead_cnt == DEAD_W'(DEADTIME - 1));
   end

   // Next-state and registered-output values
   always_comb begin
      next_state    = state;
      prescaler_nxt = tick_c ? '0 : prescaler + PRE_W'(1);
      pcnt_nxt      = tick_c ? pcnt + 5'd1 : pcnt;
      duty_nxt      = applied_duty;
      ramp_cnt_nxt  = ramp_cnt;
      dead_cnt_nxt  = dead_cnt;
      dir_nxt       = dir_out;
      target_c      = '0;

      if (fault) begin
         next_state = S_FAULT;
      end else if (state == S_FAULT) begin
         if (!enable) next_state = S_IDLE;
      end else if (brake) begin
         next_state = S_BRAKE;
      end else begin
         case (state)
            S_IDLE: begin
               if (enable) next_state = (direction != dir_out) ? S_DEADTIME : S_RUN;
            end
            S_RUN: begin
               if (!enable)                   next_state = S_RAMP_DOWN;
               else if (direction != dir_out) next_state = S_REVERSE;
            end
            S_RAMP_DOWN: begin
               if (enable)                    next_state = S_RUN;
               else if (applied_duty == '0)   next_state = S_IDLE;
            end
            S_REVERSE: begin
               if (direction == dir_out)      next_state = S_RUN;
               else if (applied_duty == '0)   next_state = S_DEADTIME;
            end
            S_DEADTIME: begin
               if (!enable)                   next_state = S_IDLE;
               else if (dead_done_c)          next_state = S_RUN;
            end
            S_BRAKE:   next_state = S_IDLE;
            default:   next_state = S_IDLE;
         endcase
      end

      cur_ramp_c = (state == S_RUN) || (state == S_RAMP_DOWN) || (state == S_REVERSE);
      nxt_ramp_c = (next_state == S_RUN) || (next_state == S_RAMP_DOWN) ||
                   (next_state == S_REVERSE);

      // Duty only slews on period boundaries; leaving the driving states zeroes it at once
      if (next_state == S_RUN) target_c = pwm;
      if (!nxt_ramp_c) begin
         duty_nxt = '0;
      end else if (cur_ramp_c && ramp_step_c) begin
         if (target_c > applied_duty)      duty_nxt = applied_duty + 5'd1;
         else if (target_c < applied_duty) duty_nxt = applied_duty - 5'd1;
      end

      if (!cur_ramp_c)   ramp_cnt_nxt = '0;
      else if (boundary_c) ramp_cnt_nxt = ramp_step_c ? '0 : ramp_cnt + RAMP_W'(1);

      if (state != S_DEADTIME) dead_cnt_nxt = '0;
      else if (boundary_c)     dead_cnt_nxt = dead_done_c ? '0 : dead_cnt + DEAD_W'(1);

      // Direction is only committed at the end of dead time, with duty still at zero
      if ((state == S_DEADTIME) && (next_state == S_RUN)) dir_nxt = direction;

      pwm_nxt   = nxt_ramp_c && (pcnt < applied_duty);
      brake_nxt = (next_state == S_BRAKE);
      fault_nxt = (next_state == S_FAULT);
      busy_nxt  = !((next_state == S_IDLE) || (next_state == S_BRAKE) ||
                    (next_state == S_FAULT));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         prescaler     <= '0;
         pcnt          <= '0;
         applied_duty  <= '0;
         ramp_cnt      <= '0;
         dead_cnt      <= '0;
         pwm_out       <= 1'b0;
         dir_out       <= 1'b0;
         brake_out     <= 1'b0;
         fault_latched <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= next_state;
         prescaler     <= prescaler_nxt;
         pcnt          <= pcnt_nxt;
         applied_duty  <= duty_nxt;
         ramp_cnt      <= ramp_cnt_nxt;
         dead_cnt      <= dead_cnt_nxt;
         pwm_out       <= pwm_nxt;
         dir_out       <= dir_nxt;
         brake_out     <= brake_nxt;
         fault_latched <= fault_nxt;
         busy          <= busy_nxt;
      end
   end

endmodule
